// File: rtl/seg7_scan_driver_if.sv
// Glyph-code and display-pin bundle between the game logic and the scan driver.
interface seg7_scan_driver_if;
    logic       load;
    logic [4:0] code0;
    logic [4:0] code1;
    logic [4:0] code2;
    logic [4:0] code3;
    logic [3:0] dp_mask;
    logic       blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output load, code0, code1, code2, code3, dp_mask, blink_en,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  load, code0, code1, code2, code3, dp_mask, blink_en,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with frame-synchronous double-buffered
// glyph codes and optional whole-display blink.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_driver_if.slave bus
);
    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [4:0]       CODE_BLANK = 5'd31;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic             slot_tick;
    logic             frame_tick_c;
    logic [3:0][4:0]  pending;
    logic [3:0][4:0]  active;
    logic             dirty;
    logic [FRM_W-1:0] frm_cnt;
    logic             blink_phase;
    logic             blank_now;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] glyph_seg(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'b1000000;
            5'd1:    s = 7'b1111001;
            5'd2:    s = 7'b0100100;
            5'd3:    s = 7'b0110000;
            5'd4:    s = 7'b0011001;
            5'd5:    s = 7'b0010010;
            5'd6:    s = 7'b0000010;
            5'd7:    s = 7'b1111000;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0010000;
            5'd10:   s = 7'b0001100;
            5'd11:   s = 7'b1000111;
            5'd12:   s = 7'b0001000;
            5'd13:   s = 7'b0010001;
            5'd14:   s = 7'b0000110;
            5'd15:   s = 7'b0101111;
            5'd16:   s = 7'b1000001;
            5'd17:   s = 7'b0101011;
            5'd18:   s = 7'b0111111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_tick    = (div_cnt == DIV_LAST);
        frame_tick_c = slot_tick && (idx == 2'd3);
        blank_now    = bus.blink_en && blink_phase;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (slot_tick) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // A load coinciding with the boundary commits the older pending codes and stays dirty.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= {4{CODE_BLANK}};
            active  <= {4{CODE_BLANK}};
            dirty   <= 1'b0;
        end else begin
            if (frame_tick_c && dirty) begin
                active <= pending;
            end
            if (bus.load) begin
                pending <= {bus.code3, bus.code2, bus.code1, bus.code0};
                dirty   <= 1'b1;
            end else if (frame_tick_c) begin
                dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.blink_en) begin
            frm_cnt     <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick_c) begin
            if (frm_cnt == FRM_LAST) begin
                frm_cnt     <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frm_cnt <= frm_cnt + 1'b1;
            end
        end
    end

    // Anode, cathodes and dp come from one register stage so they switch together.
    always_ff @(posedge clk) begin
        if (reset || blank_now) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= glyph_seg(active[idx]);
            dp_q  <= ~bus.dp_mask[idx];
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_c;
endmodule
